// File: rtl/ahfp_accum_seq_pkg.sv
// Shared definitions for the float32 reduction sequencer: FSM encoding,
// the float identity constant and the default adder latency.
package ahfp_accum_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REDUCE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
   localparam int          DEF_LATENCY = 7;

endpackage

// File: rtl/ahfp_valid_pipe.sv
// Valid-bit shadow of the external adder pipeline: a LATENCY-deep 1-bit shift
// register with async active-low clear; busy flags any bit in flight.
module ahfp_valid_pipe
   import ahfp_accum_seq_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out,
   output logic busy
);

   logic [LATENCY-1:0] vld_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | LATENCY'(in);
   end

   assign out  = vld_pipe[LATENCY-1];
   assign busy = |vld_pipe;

endmodule

// File: rtl/ahfp_accum_seq.sv
// Streaming float32 sum-reduction sequencer driving an external fixed-latency
// adder. Optional element count output enabled by AHFP_ACCUM_COUNT_EN.
module ahfp_accum_seq
   import ahfp_accum_seq_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [31:0]   add_dataa,
   output logic [31:0]   add_datab,
   input  logic [31:0]   add_result,
   output logic [31:0]   out_data,
   output logic          out_valid,
   input  logic          out_ready
`ifdef AHFP_ACCUM_COUNT_EN
   ,
   output logic [CW-1:0] out_count
`endif
);

   localparam int LW = $clog2(LATENCY + 1);

   state_t        state, state_d;
   logic [31:0]   hold, hold_d;
   logic          hold_vld, hold_vld_d;
   logic [LW-1:0] live, live_d;
   logic          issue;
   logic          accept;
   logic          pipe_out;
   logic          pipe_busy;

   assign in_ready  = (state == IDLE) || (state == ACCUM);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign out_data  = hold;

   ahfp_valid_pipe #(.LATENCY(LATENCY)) u_valid_pipe (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (issue),
      .out  (pipe_out),
      .busy (pipe_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold     <= FP_ZERO;
         hold_vld <= 1'b0;
         live     <= '0;
      end else begin
         state    <= state_d;
         hold     <= hold_d;
         hold_vld <= hold_vld_d;
         live     <= live_d;
      end
   end

   always_comb begin
      state_d    = state;
      hold_d     = hold;
      hold_vld_d = hold_vld;
      live_d     = live;
      issue      = 1'b0;
      add_dataa  = FP_ZERO;
      add_datab  = FP_ZERO;
      case (state)
         IDLE, ACCUM: begin
            // A returning partial absorbs the new element; otherwise a new chain starts.
            if (accept) begin
               issue     = 1'b1;
               add_dataa = in_data;
               if (pipe_out) add_datab = add_result;
               else          live_d    = live + LW'(1);
               state_d = in_last ? REDUCE : ACCUM;
            end else if (pipe_out) begin
               issue     = 1'b1;
               add_dataa = add_result;
            end
         end
         REDUCE: begin
            // Pair partials as they emerge, parking the odd one in hold.
            if (pipe_out) begin
               if (!hold_vld) begin
                  hold_d     = add_result;
                  hold_vld_d = 1'b1;
               end else begin
                  issue      = 1'b1;
                  add_dataa  = hold;
                  add_datab  = add_result;
                  hold_d     = FP_ZERO;
                  hold_vld_d = 1'b0;
                  live_d     = live - LW'(1);
               end
            end
            if (live == LW'(1) && hold_vld && !pipe_busy) state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d    = IDLE;
               hold_d     = FP_ZERO;
               hold_vld_d = 1'b0;
               live_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef AHFP_ACCUM_COUNT_EN
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= '0;
      else if (out_valid && out_ready)   cnt <= '0;
      else if (accept && (cnt != '1))    cnt <= cnt + CW'(1);
   end

   assign out_count = cnt;
`else
   if (CW < 1) begin : g_bad_cw
      cw_bad: assert property (@(posedge clk) 1'b0);
   end
`endif

   live_le_latency: assert property (@(posedge clk) disable iff (!rst_n)
      int'(live) <= LATENCY);

endmodule
